mips_hazard_ctrl: RTL and testbench

MIPS_HAZARD_CTRL -- requirements
Module: mips_hazard_ctrl

---
 rtl/mips_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: interlock and halt control for a 5-stage MIPS-like pipeline.
// Tracks in-flight destination registers in EX/MEM/WB scoreboard slots and
// stalls ID on read-after-write hazards against EX or MEM. A taken branch
// resolved in MEM flushes IF/ID and ID/EX. HLT blocks further issue and
// raises a sticky halted flag once it reaches WB.
// Optional feature: define HAZARD_STATS_EN to build a saturating 16-bit
// stall-cycle counter on stall_count; otherwise stall_count is tied to 0.
module mips_hazard_ctrl (
    input  logic        clk1,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_ir,
    input  logic        branch_taken,
    output logic        stall,
    output logic        flush,
    output logic        issue,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // One in-flight instruction; dest is 0 when the instruction writes nothing.
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_hlt;
    } slot_t;

    slot_t s_ex, s_mem, s_wb;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt;
    logic [4:0] id_dest;
    logic       id_is_hlt;
    logic       hazard;
    logic       halt_pending;
    logic       unused_bits;

    assign opcode = id_ir[31:26];
    assign rs     = id_ir[25:21];
    assign rt     = id_ir[20:16];
    assign rd     = id_ir[15:11];

    // Immediate/offset bits and the WB destination never affect interlocking.
    assign unused_bits = ^{id_ir[10:0], s_wb.dest};

    // A source hits when it is nonzero and matches a live destination in EX or MEM.
    // WB is excluded because the register file writes before ID reads.
    function automatic logic src_hit(input logic [4:0] src, input slot_t ex, input slot_t mem);
        logic hit;
        hit = 1'b0;
        if (src != 5'd0) begin
            if (ex.valid && (ex.dest == src))
                hit = 1'b1;
            if (mem.valid && (mem.dest == src))
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Classify the ID instruction into sources used, destination and HLT flag.
    always_comb begin
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        id_dest   = 5'd0;
        id_is_hlt = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                id_dest = rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                use_rs  = 1'b1;
                id_dest = rt;
            end
            OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                use_rs = 1'b1;
            end
            OP_HLT: begin
                id_is_hlt = 1'b1;
            end
            default: begin
                use_rs = 1'b0;
            end
        endcase
    end

    // Hazard detection and issue gating; a taken branch always overrides a stall.
    always_comb begin
        hazard       = (use_rs && src_hit(rs, s_ex, s_mem)) ||
                       (use_rt && src_hit(rt, s_ex, s_mem));
        stall        = id_valid && hazard && !branch_taken;
        flush        = branch_taken;
        halt_pending = (s_ex.valid  && s_ex.is_hlt)  ||
                       (s_mem.valid && s_mem.is_hlt) ||
                       (s_wb.valid  && s_wb.is_hlt);
        issue        = id_valid && !stall && !flush && !halt_pending && !halted;
    end

    // Advance the scoreboard; a taken branch squashes the EX and ID occupants.
    always_ff @(posedge clk1) begin
        if (rst) begin
            s_ex.valid   <= 1'b0;
            s_ex.is_hlt  <= 1'b0;
            s_mem.valid  <= 1'b0;
            s_mem.is_hlt <= 1'b0;
            s_wb.valid   <= 1'b0;
            s_wb.is_hlt  <= 1'b0;
        end else if (branch_taken) begin
            s_wb         <= s_mem;
            s_mem.valid  <= 1'b0;
            s_mem.is_hlt <= 1'b0;
            s_ex.valid   <= 1'b0;
            s_ex.is_hlt  <= 1'b0;
        end else begin
            s_wb        <= s_mem;
            s_mem       <= s_ex;
            s_ex.valid  <= issue;
            s_ex.dest   <= id_dest;
            s_ex.is_hlt <= issue && id_is_hlt;
        end
    end

    // Sticky halt: set as the HLT entry moves from MEM into WB.
    always_ff @(posedge clk1) begin
        if (rst)
            halted <= 1'b0;
        else if (s_mem.valid && s_mem.is_hlt)
            halted <= 1'b1;
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    // Count stall cycles, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk1) begin
        if (rst)
            stall_cnt_q <= 16'd0;
        else if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: expected outputs are queued when each
// step's stimulus is driven and compared when the outputs are sampled.
module tb_mips_hazard_ctrl;

    logic        clk1;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_ir;
    logic        branch_taken;
    logic        stall;
    logic        flush;
    logic        issue;
    logic        halted;
    logic [15:0] stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic        flush;
        logic        issue;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    mips_hazard_ctrl dut (
        .clk1        (clk1),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ir       (id_ir),
        .branch_taken(branch_taken),
        .stall       (stall),
        .flush       (flush),
        .issue       (issue),
        .halted      (halted),
        .stall_count (stall_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Expected counter value: only meaningful when the statistics build is enabled.
    function automatic logic [15:0] ec(input int n);
`ifdef HAZARD_STATS_EN
        return n[15:0];
`else
        return (n == -1) ? 16'd1 : 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [31:0] ir,
                        input logic br, input logic es, input logic ef, input logic ei,
                        input logic eh, input int cnt);
        exp_t e;
        rst          = r;
        id_valid     = v;
        id_ir        = ir;
        branch_taken = br;
        sb.push_back('{tag, es, ef, ei, eh, ec(cnt)});
        @(negedge clk1);
        e = sb.pop_front();
        chk({e.tag, ".stall"},  {15'd0, stall},  {15'd0, e.stall});
        chk({e.tag, ".flush"},  {15'd0, flush},  {15'd0, e.flush});
        chk({e.tag, ".issue"},  {15'd0, issue},  {15'd0, e.issue});
        chk({e.tag, ".halted"}, {15'd0, halted}, {15'd0, e.halted});
        chk({e.tag, ".cnt"},    stall_count,     e.cnt);
        @(posedge clk1);
        #1;
    endtask

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] OR_  = 6'b000011;
    localparam logic [5:0] ADDI = 6'b001010;
    localparam logic [5:0] SW   = 6'b001001;
    localparam logic [5:0] BEQZ = 6'b001110;
    localparam logic [5:0] HLT  = 6'b111111;

    initial begin
        logic [31:0] add412;
        logic [31:0] addi1;
        logic [31:0] hlt;
        add412 = rr(ADD, 5'd4, 5'd1, 5'd2);
        addi1  = ri(ADDI, 5'd1, 5'd0, 16'd10);
        hlt    = {HLT, 26'd0};

        rst = 1'b1; id_valid = 1'b0; id_ir = 32'd0; branch_taken = 1'b0;
        repeat (2) @(posedge clk1);
        #1;

        //    tag      rst  v     ir       br   stall flush issue halt cnt
        step("reset",  0, 0, 32'd0,          0, 0, 0, 0, 0, 0);
        // back-to-back RAW: two stall cycles
        step("s1a",    0, 1, addi1,          0, 0, 0, 1, 0, 0);
        step("s1b",    0, 1, add412,         0, 1, 0, 0, 0, 0);
        step("s1c",    0, 1, add412,         0, 1, 0, 0, 0, 1);
        step("s1d",    0, 1, add412,         0, 0, 0, 1, 0, 2);
        // one independent instruction in between: one stall cycle
        step("s2a",    0, 1, addi1,          0, 0, 0, 1, 0, 2);
        step("s2b",    0, 1, rr(OR_, 5'd7, 5'd7, 5'd7), 0, 0, 0, 1, 0, 2);
        step("s2c",    0, 1, add412,         0, 1, 0, 0, 0, 2);
        step("s2d",    0, 1, add412,         0, 0, 0, 1, 0, 3);
        // R0 destination never creates a hazard
        step("s2e",    0, 1, ri(ADDI, 5'd0, 5'd0, 16'd5), 0, 0, 0, 1, 0, 3);
        step("s2f",    0, 1, rr(ADD, 5'd5, 5'd0, 5'd0),   0, 0, 0, 1, 0, 3);
        // rt-source hazard via SW
        step("s2g",    0, 1, ri(SW, 5'd5, 5'd6, 16'd0),   0, 1, 0, 0, 0, 3);
        step("s2h",    0, 1, ri(SW, 5'd5, 5'd6, 16'd0),   0, 1, 0, 0, 0, 4);
        step("s2i",    0, 1, ri(SW, 5'd5, 5'd6, 16'd0),   0, 0, 0, 1, 0, 5);
        // taken branch while a dependent ADD is stalled in ID
        step("s3a",    0, 1, ri(BEQZ, 5'd0, 5'd3, 16'd4), 0, 0, 0, 1, 0, 5);
        step("s3b",    0, 1, addi1,          0, 0, 0, 1, 0, 5);
        step("s3c",    0, 1, add412,         1, 0, 1, 0, 0, 5);
        step("s3d",    0, 1, add412,         0, 0, 0, 1, 0, 5);
        // reset mid-stall with the counter at 5
        step("s4a",    1, 1, rr(OR_, 5'd8, 5'd4, 5'd0),   0, 1, 0, 0, 0, 5);
        step("s4b",    0, 1, rr(OR_, 5'd8, 5'd4, 5'd0),   0, 0, 0, 1, 0, 0);
        // HLT: issue blocked, halted three cycles after HLT issues
        step("s5a",    0, 1, hlt,            0, 0, 0, 1, 0, 0);
        step("s5b",    0, 1, rr(ADD, 5'd1, 5'd2, 5'd3),   0, 0, 0, 0, 0, 0);
        step("s5c",    0, 1, rr(ADD, 5'd1, 5'd2, 5'd3),   0, 0, 0, 0, 0, 0);
        step("s5d",    0, 1, rr(ADD, 5'd1, 5'd2, 5'd3),   0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            step($sformatf("s5h%0d", i), 0, 1, rr(ADD, 5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 1, 0);
        // reset clears halted; a branch-squashed HLT releases the pipeline
        step("s6a",    1, 0, 32'd0,          0, 0, 0, 0, 1, 0);
        step("s6b",    0, 1, ri(BEQZ, 5'd0, 5'd3, 16'd4), 0, 0, 0, 1, 0, 0);
        step("s6c",    0, 1, hlt,            0, 0, 0, 1, 0, 0);
        step("s6d",    0, 1, rr(ADD, 5'd1, 5'd2, 5'd3),   1, 0, 1, 0, 0, 0);
        step("s6e",    0, 1, rr(ADD, 5'd1, 5'd2, 5'd3),   0, 0, 0, 1, 0, 0);
        step("s6f",    0, 1, rr(ADD, 5'd9, 5'd2, 5'd3),   0, 0, 0, 1, 0, 0);
        step("s6g",    0, 0, 32'd0,          0, 0, 0, 0, 0, 0);
        step("s6h",    0, 0, 32'd0,          0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
